// File: rtl/spi_master_arbiter.sv
// SPI master for the 4-bit shift-register slave: round-robin arbitration between two
// parallel-word requesters, divided sclk, MSB-first MOSI and MISO capture into rx_data.
module spi_master_arbiter #(
    parameter int DIV   = 4,
    parameter int NBITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [NBITS-1:0] data0,
    input  logic [NBITS-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic [NBITS-1:0] rx_data,
    output logic             sclk,
    output logic             CS,
    output logic             MOSI,
    input  logic             MISO
);
    localparam int CW = $clog2(DIV) + 1;
    localparam int BW = $clog2(NBITS + 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [NBITS-1:0] tx_q, tx_d;
    logic [NBITS-1:0] rx_q, rx_d;
    logic [NBITS-1:0] rx_data_q, rx_data_d;
    logic             sclk_q, sclk_d;
    logic             cs_q, cs_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             done_q, done_d;
    logic             last_q, last_d;
    logic             cnt_end;
    logic             pick1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_data_q <= '0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            done_q    <= 1'b0;
            last_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rx_data_q <= rx_data_d;
            sclk_q    <= sclk_d;
            cs_q      <= cs_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            done_q    <= done_d;
            last_q    <= last_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rx_data_d = rx_data_q;
        sclk_d    = sclk_q;
        cs_d      = cs_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        done_d    = 1'b0;
        last_d    = last_q;
        cnt_end   = (cnt_q == CW'(DIV - 1));
        // last_q=1 means requester 1 was served last, so requester 0 wins a tie
        pick1     = req1 & (~req0 | ~last_q);

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (req0 | req1) begin
                    state_d = SETUP;
                    cs_d    = 1'b1;
                    rx_d    = '0;
                    last_d  = pick1;
                    if (pick1) begin
                        gnt1_d = 1'b1;
                        tx_d   = data1;
                    end else begin
                        gnt0_d = 1'b1;
                        tx_d   = data0;
                    end
                end
            end
            SETUP: begin
                if (cnt_end) begin
                    cnt_d   = '0;
                    sclk_d  = 1'b1;
                    rx_d    = (rx_q << 1) | NBITS'(MISO);
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SHIFT: begin
                if (cnt_end) begin
                    cnt_d  = '0;
                    sclk_d = ~sclk_q;
                    if (sclk_q) begin
                        tx_d  = tx_q << 1;
                        bit_d = bit_q + BW'(1);
                        if (bit_q == BW'(NBITS - 1)) state_d = HOLD;
                    end else begin
                        rx_d = (rx_q << 1) | NBITS'(MISO);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOLD: begin
                if (cnt_end) begin
                    cnt_d     = '0;
                    state_d   = DONE;
                    done_d    = 1'b1;
                    cs_d      = 1'b0;
                    rx_data_d = rx_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign sclk    = sclk_q;
    assign CS      = cs_q;
    assign MOSI    = ((state_q == SETUP) || (state_q == SHIFT)) ? tx_q[NBITS-1] : 1'b0;
endmodule

// File: tb/tb_spi_master_arbiter.sv
// Bench for spi_master_arbiter: DIV=4 and DIV=1 instances, a loopback slave model on MISO,
// a vector table for arbitration patterns and hand-written reset/late-request sequences.
module tb_spi_master_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         s_req0, s_req1, s_gnt0, s_gnt1, s_busy, s_done, s_sclk, s_cs, s_mosi, s_miso;
    logic [N-1:0] s_data0, s_data1, s_rx;
    logic         f_req0, f_req1, f_gnt0, f_gnt1, f_busy, f_done, f_sclk, f_cs, f_mosi, f_miso;
    logic [N-1:0] f_data0, f_data1, f_rx;
    logic         miso_inv, sel;

    spi_master_arbiter #(.DIV(4), .NBITS(N)) u_slow (
        .clk(clk), .rst(rst), .req0(s_req0), .req1(s_req1), .data0(s_data0), .data1(s_data1),
        .gnt0(s_gnt0), .gnt1(s_gnt1), .busy(s_busy), .done(s_done), .rx_data(s_rx),
        .sclk(s_sclk), .CS(s_cs), .MOSI(s_mosi), .MISO(s_miso)
    );

    spi_master_arbiter #(.DIV(1), .NBITS(N)) u_fast (
        .clk(clk), .rst(rst), .req0(f_req0), .req1(f_req1), .data0(f_data0), .data1(f_data1),
        .gnt0(f_gnt0), .gnt1(f_gnt1), .busy(f_busy), .done(f_done), .rx_data(f_rx),
        .sclk(f_sclk), .CS(f_cs), .MOSI(f_mosi), .MISO(f_miso)
    );

    // The slave returns what it is sent (optionally inverted), gated by CS.
    assign s_miso = miso_inv ^ (s_mosi & s_cs);
    assign f_miso = f_mosi & f_cs;

    logic         m_g0, m_g1, m_sclk, m_mosi, m_cs, m_done, m_busy;
    logic [N-1:0] m_rx;
    assign m_g0   = sel ? f_gnt0 : s_gnt0;
    assign m_g1   = sel ? f_gnt1 : s_gnt1;
    assign m_sclk = sel ? f_sclk : s_sclk;
    assign m_mosi = sel ? f_mosi : s_mosi;
    assign m_cs   = sel ? f_cs   : s_cs;
    assign m_done = sel ? f_done : s_done;
    assign m_busy = sel ? f_busy : s_busy;
    assign m_rx   = sel ? f_rx   : s_rx;

    logic [N-1:0] leds;
    always @(posedge m_sclk or posedge rst) begin
        if (rst) leds <= '0;
        else     leds <= {leds[N-2:0], m_mosi & m_cs};
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int done_cnt = 0;
    always @(negedge clk) if (s_done) done_cnt <= done_cnt + 1;

    int checks = 0;
    int failures = 0;
    int last_gnt = 0;
    logic [N-1:0] sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drop_reqs();
        s_req0 = 1'b0; s_req1 = 1'b0; f_req0 = 1'b0; f_req1 = 1'b0;
    endtask

    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m_g0 | m_g1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_frame(input int exp_g, input int gap, input bit drop,
                               input logic [N-1:0] tx, input int div);
        bit ok, prev, bad, fin;
        int t0, k;
        logic [N-1:0] exp_rx;
        wait_gnt(ok);
        chk("grant_seen", ok, 1);
        if (!ok) return;
        t0 = cyc;
        chk("grant_id", {m_g1, m_g0}, (exp_g != 0) ? 2'b10 : 2'b01);
        if (gap > 0) chk("grant_gap", t0 - last_gnt, gap);
        last_gnt = t0;
        if (drop) drop_reqs();
        chk("cs_at_grant", m_cs, 1);
        chk("busy_at_grant", m_busy, 1);
        chk("mosi_at_grant", m_mosi, tx[N-1]);
        k = 0; prev = 1'b0; bad = 1'b0; fin = 1'b0;
        for (int i = 0; i < 200 && !fin; i++) begin
            @(negedge clk);
            if (m_g0 | m_g1) bad = 1'b1;
            if (m_sclk && !prev) begin
                chk("rise_time", cyc - t0, (2 * k + 1) * div);
                if (k < N) chk("mosi_bit", m_mosi, tx[N-1-k]);
                k++;
            end
            prev = m_sclk;
            if (m_done) fin = 1'b1;
            else if (!m_cs || !m_busy) bad = 1'b1;
        end
        chk("done_seen", fin, 1);
        if (!fin) return;
        chk("done_time", cyc - t0, (2 * N + 1) * div);
        chk("rise_count", k, N);
        chk("frame_window", bad, 0);
        chk("cs_low_at_done", m_cs, 0);
        chk("sclk_low_at_done", m_sclk, 0);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            exp_rx = sb.pop_front();
            chk("rx_data", m_rx, exp_rx);
        end
        chk("slave_leds", leds, tx);
        @(negedge clk);
        chk("done_one_cycle", m_done, 0);
        chk("idle_after_done", m_busy, 0);
    endtask

    typedef struct {
        bit         r0;
        bit         r1;
        logic [N-1:0] d0;
        logic [N-1:0] d1;
        bit         inv;
        int         frames;
        bit         first_g;
    } vec_t;

    vec_t vecs[5];
    int g, t0, dc;
    logic [N-1:0] tx;
    bit ok;

    initial begin
        vecs[0] = '{1'b1, 1'b0, 4'b1011, 4'h0, 1'b0, 1, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 4'h0, 4'b0110, 1'b0, 1, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 4'h5, 4'hA, 1'b0, 4, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 4'h3, 4'h0, 1'b1, 1, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 4'h0, 4'hF, 1'b0, 2, 1'b1};

        drop_reqs();
        s_data0 = '0; s_data1 = '0; f_data0 = '0; f_data1 = '0;
        miso_inv = 1'b0; sel = 1'b0;

        #1;
        chk("rst_sclk", s_sclk, 0);
        chk("rst_cs", s_cs, 0);
        chk("rst_mosi", s_mosi, 0);
        chk("rst_gnt", {s_gnt1, s_gnt0}, 0);
        chk("rst_busy", s_busy, 0);
        chk("rst_done", s_done, 0);
        chk("rst_rx", s_rx, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            s_req0 = vecs[v].r0; s_req1 = vecs[v].r1;
            s_data0 = vecs[v].d0; s_data1 = vecs[v].d1;
            miso_inv = vecs[v].inv;
            for (int f = 0; f < vecs[v].frames; f++) begin
                if (vecs[v].r0 && vecs[v].r1) g = int'(vecs[v].first_g) ^ (f % 2);
                else                          g = vecs[v].r1 ? 1 : 0;
                tx = (g != 0) ? vecs[v].d1 : vecs[v].d0;
                sb.push_back(tx ^ {N{vecs[v].inv}});
                check_frame(g, (f > 0) ? 38 : 0, f == vecs[v].frames - 1, tx, 4);
            end
        end
        miso_inv = 1'b0;

        // Late request: req1 appears 10 cycles into a req0 frame; req0 drops after its grant.
        @(negedge clk);
        s_req0 = 1'b1; s_data0 = 4'h9;
        sb.push_back(4'h9);
        sb.push_back(4'h6);
        fork
            check_frame(0, 0, 1'b1, 4'h9, 4);
            begin
                bit okl;
                wait_gnt(okl);
                if (okl) begin
                    repeat (10) @(negedge clk);
                    s_req1 = 1'b1; s_data1 = 4'h6;
                end
            end
        join
        check_frame(1, 38, 1'b1, 4'h6, 4);

        // Mid-frame asynchronous reset aborts the frame.
        @(negedge clk);
        s_req0 = 1'b1; s_data0 = 4'hC;
        wait_gnt(ok);
        chk("mid_grant_seen", ok, 1);
        drop_reqs();
        repeat (15) @(negedge clk);
        chk("cs_before_rst", s_cs, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_cs", s_cs, 0);
        chk("mid_rst_sclk", s_sclk, 0);
        chk("mid_rst_busy", s_busy, 0);
        chk("mid_rst_mosi", s_mosi, 0);
        chk("mid_rst_rx", s_rx, 0);
        dc = done_cnt;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("no_done_after_abort", done_cnt, dc);
        chk("rx_kept_after_abort", s_rx, 0);
        s_req1 = 1'b1; s_data1 = 4'hA;
        sb.push_back(4'hA);
        check_frame(1, 0, 1'b1, 4'hA, 4);

        // Asynchronous reset while idle clears rx_data at once.
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("idle_rst_rx", s_rx, 0);
        chk("idle_rst_busy", s_busy, 0);
        @(negedge clk);
        rst = 1'b0;

        // DIV=1 instance: rises at 1,3,5,7, done at 9, back-to-back grants 11 apart.
        @(negedge clk);
        sel = 1'b1;
        f_req0 = 1'b1; f_data0 = 4'b1101;
        sb.push_back(4'b1101);
        check_frame(0, 0, 1'b1, 4'b1101, 1);
        @(negedge clk);
        f_req0 = 1'b1; f_req1 = 1'b1; f_data0 = 4'h2; f_data1 = 4'h7;
        sb.push_back(4'h7);
        check_frame(1, 0, 1'b0, 4'h7, 1);
        sb.push_back(4'h2);
        check_frame(0, 11, 1'b1, 4'h2, 1);

        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
